fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Shared word types plus the fetch unit's memory-side and instruction-side bus.
// master = fetch unit, slave = memory model / downstream splitter.
package definitions_pkg;
  typedef logic [31:0] dword_t;
  typedef logic [15:0] word_t;

  typedef struct packed {
    word_t instruction;
    word_t absolute;
  } opcode_t;
endpackage

interface fetch_unit_if;
  import definitions_pkg::*;

  logic   mem_req;
  dword_t mem_addr;
  logic   mem_gnt;
  logic   mem_rvalid;
  dword_t mem_rdata;
  logic   instr_valid;
  dword_t instr_word;
  dword_t instr_pc;
  logic   instr_ready;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output instr_valid, instr_word, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  instr_valid, instr_word, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory reads into a DEPTH-entry FIFO, 3 cycles enable->instr_valid.
// Backpressure via credit (fifo count + outstanding < DEPTH); redirect flushes FIFO and drains in-flight data.
module fetch_unit
  import definitions_pkg::*;
#(
  parameter dword_t RESET_PC = 32'h0000_0000,
  parameter int     PC_STEP  = 4,
  parameter int     DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         redirect_valid,
  input  dword_t       redirect_pc,
  fetch_unit_if.master bus,
  output logic         busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t          state;
  dword_t          pc;
  dword_t          req_pc;
  dword_t          word_q [DEPTH];
  dword_t          pc_q   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A redirect cancels both the same-cycle push and the same-cycle pop.
  assign push      = (state == WAIT) && bus.mem_rvalid && !redirect_valid;
  assign pop       = bus.instr_valid && bus.instr_ready && !redirect_valid;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign bus.mem_req     = (state == REQ);
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_word  = word_q[rd_ptr];
  assign bus.instr_pc    = pc_q[rd_ptr];
  assign busy            = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      case (state)
        IDLE:    state <= IDLE;
        REQ:     state <= bus.mem_gnt ? DRAIN : IDLE;
        WAIT:    state <= bus.mem_rvalid ? IDLE : DRAIN;
        DRAIN:   state <= bus.mem_rvalid ? IDLE : DRAIN;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (enable && (count < CW'(DEPTH))) state <= REQ;
        end
        REQ: begin
          if (bus.mem_gnt) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            pc    <= req_pc + dword_t'(PC_STEP);
            state <= (enable && (count_nxt < CW'(DEPTH))) ? REQ : IDLE;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        word_q[wr_ptr] <= bus.mem_rdata;
        pc_q[wr_ptr]   <= req_pc;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table with an auto zero-wait memory,
// then hand-driven redirect, reset-in-flight and PC-wrap sequences.
module tb_fetch_unit;
  import definitions_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   en = 1'b0;
  logic   rdy = 1'b0;
  logic   redir_vld = 1'b0;
  dword_t redir_pc = '0;
  logic   busy;

  logic   auto_mem = 1'b1;
  logic   man_gnt = 1'b0;
  logic   man_rvalid = 1'b0;
  dword_t man_rdata = '0;
  logic   auto_rv = 1'b0;
  dword_t auto_rd = '0;

  logic   en_w = 1'b0;
  logic   busy_w;
  logic   auto_rv_w = 1'b0;
  dword_t auto_rd_w = '0;

  int total = 0;
  int bad = 0;

  fetch_unit_if bus ();
  fetch_unit_if bus_w ();

  fetch_unit dut (
    .clk(clk), .reset(reset), .enable(en), .redirect_valid(redir_vld),
    .redirect_pc(redir_pc), .bus(bus.master), .busy(busy)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .enable(en_w), .redirect_valid(1'b0),
    .redirect_pc(32'h0), .bus(bus_w.master), .busy(busy_w)
  );

  always #5 clk = ~clk;

  function automatic dword_t memfn(input dword_t a);
    return (a == 32'h0) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
  endfunction

  // Zero-wait memory: grant with request, data one cycle after grant.
  always @(posedge clk) begin
    auto_rv   <= bus.mem_req & bus.mem_gnt & auto_mem;
    auto_rd   <= memfn(bus.mem_addr);
    auto_rv_w <= bus_w.mem_req & bus_w.mem_gnt;
    auto_rd_w <= memfn(bus_w.mem_addr);
  end

  assign bus.mem_gnt      = auto_mem ? bus.mem_req : man_gnt;
  assign bus.mem_rvalid   = auto_mem ? auto_rv : man_rvalid;
  assign bus.mem_rdata    = auto_mem ? auto_rd : man_rdata;
  assign bus.instr_ready  = rdy;
  assign bus_w.mem_gnt    = bus_w.mem_req;
  assign bus_w.mem_rvalid = auto_rv_w;
  assign bus_w.mem_rdata  = auto_rd_w;
  assign bus_w.instr_ready = 1'b1;

  task automatic chk(input string name, input dword_t act, input dword_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic   en;
    logic   rdy;
    logic   req;
    dword_t addr;
    logic   iv;
    dword_t word;
    dword_t ipc;
    logic   bsy;
  } vec_t;

  vec_t   tbl [13];
  opcode_t op;

  initial begin
    //            en rdy req addr         iv word           ipc          busy
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0,         32'h0,  1'b1};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0,         32'h0,  1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'hDEADBEEF,  32'h0,  1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h04, 1'b1, 32'hDEADBEEF,  32'h0,  1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'hDEADBEEF,  32'h0,  1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 32'hDEADBEEF,  32'h0,  1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'hC0DE0004,  32'h4,  1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'hC0DE0004,  32'h4,  1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b0, 32'h0,         32'h0,  1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'hC0DE0008,  32'h8,  1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0C, 1'b0, 32'h0,         32'h0,  1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 32'hC0DE000C,  32'hC,  1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h10, 1'b0, 32'h0,         32'h0,  1'b0};

    repeat (3) step();
    chk("rst_req",   32'(bus.mem_req), 32'h0);
    chk("rst_addr",  bus.mem_addr, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_word",  bus.instr_word, 32'h0);
    chk("rst_ipc",   bus.instr_pc, 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_addr_w", bus_w.mem_addr, 32'hFFFF_FFFC);
    reset = 1'b0;

    // Streaming and backpressure against the zero-wait memory.
    for (int i = 0; i < 13; i++) begin
      en  = tbl[i].en;
      rdy = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_req", i),   32'(bus.mem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),  bus.mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(tbl[i].iv));
      chk($sformatf("v%0d_busy", i),  32'(busy), 32'(tbl[i].bsy));
      if (tbl[i].iv) begin
        chk($sformatf("v%0d_word", i), bus.instr_word, tbl[i].word);
        chk($sformatf("v%0d_ipc", i),  bus.instr_pc, tbl[i].ipc);
      end
      if (i == 2) begin
        op = opcode_t'(bus.instr_word);
        chk("split_instruction", 32'(op.instruction), 32'h0000_DEAD);
        chk("split_absolute",    32'(op.absolute),    32'h0000_BEEF);
      end
    end

    // Redirect while waiting for the response to address 4.
    auto_mem = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    en = 1'b1; rdy = 1'b0;
    step();
    chk("a_req0", bus.mem_addr, 32'h0);
    man_gnt = 1'b1; step();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; step();
    chk("a_word0", bus.instr_word, 32'hDEAD_BEEF);
    man_rvalid = 1'b0; man_gnt = 1'b1; step();
    chk("a_wait_addr", bus.mem_addr, 32'h4);
    man_gnt = 1'b0; redir_vld = 1'b1; redir_pc = 32'h100; step();
    chk("a_flush_valid", 32'(bus.instr_valid), 32'h0);
    chk("a_drain_busy",  32'(busy), 32'h1);
    chk("a_drain_req",   32'(bus.mem_req), 32'h0);
    chk("a_drain_addr",  bus.mem_addr, 32'h100);
    redir_vld = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_0BAD; step();
    chk("a_discard_valid", 32'(bus.instr_valid), 32'h0);
    chk("a_idle_busy",     32'(busy), 32'h0);
    man_rvalid = 1'b0; step();
    chk("a_rereq", 32'(bus.mem_req), 32'h1);
    chk("a_rereq_addr", bus.mem_addr, 32'h100);

    // Redirect together with rvalid, then redirect in REQ without grant.
    man_gnt = 1'b1; step();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_1234;
    redir_vld = 1'b1; redir_pc = 32'h200; step();
    chk("b_rv_valid", 32'(bus.instr_valid), 32'h0);
    chk("b_rv_busy",  32'(busy), 32'h0);
    chk("b_rv_addr",  bus.mem_addr, 32'h200);
    redir_vld = 1'b0; man_rvalid = 1'b0; step();
    chk("b_req200", 32'(bus.mem_req), 32'h1);
    redir_vld = 1'b1; redir_pc = 32'h300; step();
    chk("b_drop_req",  32'(bus.mem_req), 32'h0);
    chk("b_drop_addr", bus.mem_addr, 32'h300);
    chk("b_drop_valid", 32'(bus.instr_valid), 32'h0);
    redir_vld = 1'b0; step();
    chk("b_rereq", 32'(bus.mem_req), 32'h1);
    chk("b_rereq_addr", bus.mem_addr, 32'h300);
    man_gnt = 1'b1; step();
    man_gnt = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hCAFE_0300; step();
    chk("b_push_word", bus.instr_word, 32'hCAFE_0300);
    chk("b_push_ipc",  bus.instr_pc, 32'h300);

    // Reset while in WAIT, then a stale response.
    man_rvalid = 1'b0; man_gnt = 1'b1; step();
    man_gnt = 1'b0; en = 1'b0; reset = 1'b1; step();
    chk("c_rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("c_rst_req",   32'(bus.mem_req), 32'h0);
    chk("c_rst_busy",  32'(busy), 32'h0);
    chk("c_rst_addr",  bus.mem_addr, 32'h0);
    chk("c_rst_word",  bus.instr_word, 32'h0);
    chk("c_rst_ipc",   bus.instr_pc, 32'h0);
    reset = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h0000_FFFF; step();
    chk("c_late_valid", 32'(bus.instr_valid), 32'h0);
    chk("c_late_busy",  32'(busy), 32'h0);
    man_rvalid = 1'b0; en = 1'b1; step();
    chk("c_req",  32'(bus.mem_req), 32'h1);
    chk("c_addr", bus.mem_addr, 32'h0);
    en = 1'b0;

    // PC wrap on the second instance.
    en_w = 1'b1; step();
    chk("w_req0",  32'(bus_w.mem_req), 32'h1);
    chk("w_addr0", bus_w.mem_addr, 32'hFFFF_FFFC);
    step(); step();
    chk("w_req1",  32'(bus_w.mem_req), 32'h1);
    chk("w_addr1", bus_w.mem_addr, 32'h0);
    chk("w_valid", 32'(bus_w.instr_valid), 32'h1);
    chk("w_word",  bus_w.instr_word, 32'hC0DE_FFFC);
    chk("w_ipc",   bus_w.instr_pc, 32'hFFFF_FFFC);
    en_w = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
